conv2d_window_gen: RTL

Parametrised successor to the fixed 5×5 / 3×3 convolution address sequencer. For every output pixel it walks a K×K window and issues one memory read per tap. It then streams the tap data, with per-window framing, to the MAC/buffer stage. It adds several things the fixed sequencer lacks:
- runtime image size;
- stride 1/2;
- zero or replicate padding;
- a base address;
- downstream back-pressure;
- abort.

---
 rtl/conv2d_pkg.sv | 28 ++
 rtl/conv2d_window_gen_if.sv | 24 ++
 rtl/conv2d_tap_addr.sv | 47 ++++
 rtl/conv2d_window_gen.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
// Shared types and coordinate helpers for the K x K window sequencer.
package conv2d_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef enum logic {
      PAD_ZERO = 1'b0,
      PAD_REP  = 1'b1
   } pad_mode_e;

   function automatic logic in_range(int v, int dim);
      return (v >= 0) && (v < dim);
   endfunction

   function automatic int clamp(int v, int dim);
      if (v < 0)
         return 0;
      if (v >= dim)
         return dim - 1;
      return v;
   endfunction

endpackage

// File: rtl/conv2d_window_gen_if.sv
// Tap stream toward the MAC/buffer stage, one beat per window tap.
interface conv2d_window_gen_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 12
);

   logic              tap_valid;
   logic              tap_ready;
   logic [DATA_W-1:0] tap_data;
   logic              tap_first;
   logic              tap_last;
   logic [ADDR_W-1:0] WriteAddress;

   modport master (
      output tap_valid, tap_data, tap_first, tap_last, WriteAddress,
      input  tap_ready
   );

   modport slave (
      input  tap_valid, tap_data, tap_first, tap_last, WriteAddress,
      output tap_ready
   );

endinterface

// File: rtl/conv2d_tap_addr.sv
// Window position -> image coordinate, pad/clamp decision and read address.
module conv2d_tap_addr
   import conv2d_pkg::*;
#(
   parameter int ADDR_W = 17,
   parameter int DIM_W  = 8,
   parameter int K      = 3,
   parameter int KW     = 2
) (
   input  logic [DIM_W-1:0]  orow,
   input  logic [DIM_W-1:0]  ocol,
   input  logic [KW-1:0]     r,
   input  logic [KW-1:0]     c,
   input  logic [DIM_W-1:0]  rows,
   input  logic [DIM_W-1:0]  cols,
   input  logic              s2,
   input  pad_mode_e         pm,
   input  logic [ADDR_W-1:0] base,
   output logic              rd,
   output logic [ADDR_W-1:0] addr
);

   localparam int CW = DIM_W + 2;
   localparam int P  = (K - 1) / 2;

   logic [CW-1:0]        rb, cb;
   logic signed [CW-1:0] ir, ic;
   logic [2*DIM_W-1:0]   prod;
   int                   iri, ici, cr, cc;

   always_comb begin
      rb   = s2 ? {1'b0, orow, 1'b0} : {2'b00, orow};
      cb   = s2 ? {1'b0, ocol, 1'b0} : {2'b00, ocol};
      ir   = $signed(rb + CW'(r) - CW'(P));
      ic   = $signed(cb + CW'(c) - CW'(P));
      iri  = int'(ir);
      ici  = int'(ic);
      rd   = (in_range(iri, int'(rows)) && in_range(ici, int'(cols)))
             || (pm == PAD_REP);
      // zero-mode pad taps never reach memory, so clamping them is harmless
      cr   = clamp(iri, int'(rows));
      cc   = clamp(ici, int'(cols));
      prod = (2*DIM_W)'(DIM_W'(cr)) * (2*DIM_W)'(cols);
      addr = base + ADDR_W'(prod) + ADDR_W'(DIM_W'(cc));
   end

endmodule

// File: rtl/conv2d_window_gen.sv
// K x K window read sequencer with a 2-stage address/tap pipeline.
module conv2d_window_gen
   import conv2d_pkg::*;
#(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 12,
   parameter int DIM_W  = 8,
   parameter int K      = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [DIM_W-1:0]    num_rows,
   input  logic [DIM_W-1:0]    num_cols,
   input  logic                stride2,
   input  logic                pad_rep,
   input  logic [ADDR_W-1:0]   base_addr,
   output logic                rd_en,
   output logic [ADDR_W-1:0]   ReadAddress,
   input  logic [DATA_W-1:0]   d_in,
   conv2d_window_gen_if.master tap,
   output logic                ready
);

   localparam int            KW = $clog2(K + 1);
   localparam logic [KW-1:0] KM = KW'(K - 1);

   state_e            state, state_nx;
   logic [DIM_W-1:0]  rows_q, cols_q, orows, ocols;
   logic [DIM_W-1:0]  orow, ocol;
   logic [KW-1:0]     r, c;
   logic              s2_q;
   pad_mode_e         pm_q;
   logic [ADDR_W-1:0] base_q, waddr, tap_addr;
   logic              tap_rd, adv, issue, last_tap, start_ok;
   logic              tv, pad2, first2, last2, ready_q;
   logic [ADDR_W-1:0] wa2;

   assign orows = s2_q ? DIM_W'(({1'b0, rows_q} + 1) >> 1) : rows_q;
   assign ocols = s2_q ? DIM_W'(({1'b0, cols_q} + 1) >> 1) : cols_q;

   conv2d_tap_addr #(
      .ADDR_W(ADDR_W), .DIM_W(DIM_W), .K(K), .KW(KW)
   ) u_addr (
      .orow(orow), .ocol(ocol), .r(r), .c(c),
      .rows(rows_q), .cols(cols_q), .s2(s2_q), .pm(pm_q),
      .base(base_q), .rd(tap_rd), .addr(tap_addr)
   );

   assign adv      = !tv || tap.tap_ready;
   assign issue    = (state == RUN) && adv && !abort;
   assign last_tap = (r == KM) && (c == KM)
                     && (ocol == ocols - 1'b1) && (orow == orows - 1'b1);
   assign start_ok = start && !abort
                     && ((state == IDLE) || (state == DONE));

   assign rd_en       = issue && tap_rd;
   assign ReadAddress = rd_en ? tap_addr : '0;

   always_comb begin
      state_nx = state;
      if (abort) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE, DONE:
               if (start)
                  state_nx = (num_rows == '0 || num_cols == '0) ? DONE : RUN;
            RUN:
               if (issue && last_tap)
                  state_nx = DRAIN;
            DRAIN:
               if (adv)
                  state_nx = DONE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ready_q <= 1'b0;
      end else begin
         state   <= state_nx;
         ready_q <= (state_nx == DONE);
      end
   end

   // c/r wrap into ocol/orow in the same cycle so windows run back to back
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r      <= '0;
         c      <= '0;
         ocol   <= '0;
         orow   <= '0;
         waddr  <= '0;
         rows_q <= '0;
         cols_q <= '0;
         s2_q   <= 1'b0;
         pm_q   <= PAD_ZERO;
         base_q <= '0;
      end else if (start_ok) begin
         r      <= '0;
         c      <= '0;
         ocol   <= '0;
         orow   <= '0;
         waddr  <= '0;
         rows_q <= num_rows;
         cols_q <= num_cols;
         s2_q   <= stride2;
         pm_q   <= pad_mode_e'(pad_rep);
         base_q <= base_addr;
      end else if (issue) begin
         if (r != KM) begin
            r <= r + 1'b1;
         end else begin
            r <= '0;
            if (c != KM) begin
               c <= c + 1'b1;
            end else begin
               c     <= '0;
               waddr <= waddr + 1'b1;
               if (ocol != ocols - 1'b1) begin
                  ocol <= ocol + 1'b1;
               end else begin
                  ocol <= '0;
                  orow <= orow + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tv     <= 1'b0;
         pad2   <= 1'b0;
         first2 <= 1'b0;
         last2  <= 1'b0;
         wa2    <= '0;
      end else if (abort) begin
         tv <= 1'b0;
      end else if (adv) begin
         tv <= issue;
         if (issue) begin
            pad2   <= !tap_rd;
            first2 <= (r == '0) && (c == '0);
            last2  <= (r == KM) && (c == KM);
            wa2    <= waddr;
         end
      end
   end

   // memory holds d_in while rd_en is low, so a stalled tap stays valid
   assign tap.tap_valid    = tv;
   assign tap.tap_data     = (tv && !pad2) ? d_in : '0;
   assign tap.tap_first    = tv && first2;
   assign tap.tap_last     = tv && last2;
   assign tap.WriteAddress = wa2;
   assign ready            = ready_q;

endmodule
